// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One product or quotient bit per cycle, then a single sign-fix cycle.
module muldiv_unit #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wd,
    output logic         busy,
    output logic         done,
    output logic         div0,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           is_div_q, is_div_d;
    logic           neg_q, neg_d;
    logic           rneg_q, rneg_d;
    logic           zero_q, zero_d;
    logic [N-1:0]   ina_q, ina_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   p_hi_q, p_hi_d;
    logic [N-1:0]   p_lo_q, p_lo_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic           done_q, done_d;
    logic           div0_q, div0_d;

    logic           signed_op;
    logic           a_neg, b_neg;
    logic [N-1:0]   a_mag, b_mag;
    logic [N:0]     mul_sum;
    logic [N:0]     div_sh;
    logic [N:0]     div_rem;
    logic           div_ge;
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   quo_fix, rem_fix;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & inA[N-1];
    assign b_neg     = signed_op & inB[N-1];
    assign a_mag     = a_neg ? -inA : inA;
    assign b_mag     = b_neg ? -inB : inB;

    // a_q holds the multiplicand or the divisor magnitude
    assign mul_sum = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, a_q} : '0);
    assign div_sh  = {p_hi_q, p_lo_q[N-1]};
    assign div_ge  = div_sh >= {1'b0, a_q};
    assign div_rem = div_ge ? div_sh - {1'b0, a_q} : div_sh;

    assign prod_fix = neg_q ? -{p_hi_q, p_lo_q} : {p_hi_q, p_lo_q};
    assign quo_fix  = neg_q ? -p_lo_q : p_lo_q;
    assign rem_fix  = rneg_q ? -p_hi_q : p_hi_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        zero_d   = zero_q;
        ina_d    = ina_q;
        a_d      = a_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        div0_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d = op[1];
                    zero_d   = op[1] & (inB == '0);
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = op[1] & a_neg;
                    ina_d    = inA;
                    a_d      = op[1] ? b_mag : a_mag;
                    p_lo_d   = op[1] ? a_mag : b_mag;
                    p_hi_d   = '0;
                    cnt_d    = CW'(N);
                    state_d  = RUN;
                end else begin
                    if (hi_we) hi_d = wd;
                    if (lo_we) lo_d = wd;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    p_hi_d = div_rem[N-1:0];
                    p_lo_d = {p_lo_q[N-2:0], div_ge};
                end else begin
                    p_hi_d = mul_sum[N:1];
                    p_lo_d = {mul_sum[0], p_lo_q[N-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    if (zero_q) begin
                        lo_d   = '1;
                        hi_d   = ina_q;
                        div0_d = 1'b1;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            zero_q   <= 1'b0;
            ina_q    <= '0;
            a_q      <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            zero_q   <= zero_d;
            ina_q    <= ina_d;
            a_q      <= a_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and corner-case operations
// checked against plain-arithmetic expectations.
module tb_muldiv_unit;

    localparam int N = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] inA, inB, wd;
    logic         hi_we, lo_we;
    logic         busy, done, div0;
    logic [N-1:0] hi, lo;

    muldiv_unit #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .inA   (inA),
        .inB   (inB),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] last_hi, last_lo;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic void model(input logic [1:0] o,
                                  input logic [31:0] a, b,
                                  output logic [31:0] eh, el,
                                  output logic ez);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        ez = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            2'b00: begin
                p = 64'(longint'(sa) * longint'(sb));
                {eh, el} = p;
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                {eh, el} = p;
            end
            2'b10: begin
                if (b == 0) begin
                    el = '1; eh = a; ez = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000; eh = '0;
                end else begin
                    el = sa / sb;
                    eh = sa % sb;
                end
            end
            default: begin
                if (b == 0) begin
                    el = '1; eh = a; ez = 1'b1;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endfunction

    // monitor: every done pulse must match the oldest outstanding request
    always @(negedge clock) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)",
                         cyc);
            end else begin
                e = sbq.pop_front();
                chk("result_hi", hi, e.hi);
                chk("result_lo", lo, e.lo);
                chk("result_div0", {31'b0, div0}, {31'b0, e.z});
                chk("done_cycle", cyc, e.cyc);
                chk("busy_in_done", {31'b0, busy}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, b,
                         input logic with_we);
        exp_t e;
        model(o, a, b, e.hi, e.lo, e.z);
        op    = o;
        inA   = a;
        inB   = b;
        start = 1'b1;
        hi_we = with_we;
        lo_we = with_we;
        wd    = 32'h1234;
        @(posedge clock); #1;
        e.cyc = cyc + N + 1;
        sbq.push_back(e);
        last_hi = e.hi;
        last_lo = e.lo;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        op    = 2'($urandom);
        inA   = $urandom;
        inB   = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got busy=%b expected 0", busy);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ph, pl;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        inA   = '0;
        inB   = '0;
        wd    = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_div0", {31'b0, div0}, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // MTHI/MTLO in idle
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'hA5A5_A5A5;
        @(posedge clock); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mt_hi", hi, 32'hA5A5_A5A5);
        chk("mt_lo", lo, 32'hA5A5_A5A5);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        chk("hold_hi_while_busy", hi, 32'hA5A5_A5A5);
        wait_idle();
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        issue(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
        wait_idle();
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle();
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        issue(2'b11, 32'd100, 32'd0, 1'b0);
        wait_idle();
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        chk("divu0_hi", hi, 32'd100);
        chk("divu0_flag", {31'b0, div0}, 32'd1);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'h0);
        chk("ovf_div0", {31'b0, div0}, 32'd0);

        // start and writes while busy are ignored
        ph = last_hi;
        pl = last_lo;
        issue(2'b11, 32'd1000, 32'd7, 1'b0);
        repeat (5) @(posedge clock);
        #1;
        start = 1'b1; op = 2'b00; inA = 32'd9; inB = 32'd9;
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'h1234;
        @(posedge clock); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk("busy_hold_hi", hi, ph);
        chk("busy_hold_lo", lo, pl);
        wait_idle();
        chk("busy_ign_lo", lo, 32'd142);
        chk("busy_ign_hi", hi, 32'd6);

        // reset in the middle of a DIVU
        issue(2'b11, 32'd123456, 32'd77, 1'b0);
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        void'(sbq.pop_back());
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        repeat (N + 5) @(posedge clock);
        #1;
        issue(2'b11, 32'd123456, 32'd77, 1'b0);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick(),
                  1'($urandom_range(0, 1)));
            wait_idle();
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clock); #1;
            end
        end

        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
